// File: rtl/bpred_pkg.sv
// Shared defaults, outcome encoding and in-flight entry layout for the
// branch-predictor update queue.
package bpred_pkg;

  localparam int unsigned BPRED_WIDTH_DEFAULT = 8;
  localparam int unsigned QUEUE_DEPTH_DEFAULT = 4;

  // Entry fields are sized for the widest supported BPRED_WIDTH; narrower
  // instances zero-extend on push and truncate on read.
  localparam int unsigned BPRED_MAX_WIDTH = 32;

  localparam logic OUTCOME_TAKEN     = 1'b1;
  localparam logic OUTCOME_NOT_TAKEN = 1'b0;

  typedef struct packed {
    logic [BPRED_MAX_WIDTH-1:0] index;
    logic                       prediction;
    logic [BPRED_MAX_WIDTH-1:0] ghr_snapshot;
  } bpred_entry_t;

endpackage

// File: rtl/bpred_entry_fifo.sv
// Circular buffer of in-flight branch entries with push, pop and whole-queue
// flush; DEPTH must be a power of two so the pointers wrap naturally.
module bpred_entry_fifo
  import bpred_pkg::*;
#(
  parameter int unsigned DEPTH = QUEUE_DEPTH_DEFAULT
) (
  input  logic         i_Clk,
  input  logic         i_Reset_n,
  input  logic         i_Push,
  input  bpred_entry_t i_Push_Entry,
  input  logic         i_Pop,
  input  logic         i_Flush,
  output bpred_entry_t o_Head,
  output logic         o_Full,
  output logic         o_Empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  bpred_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (i_Push) wr_ptr <= wr_ptr + 1'b1;
      if (i_Pop)  rd_ptr <= rd_ptr + 1'b1;
      if (i_Push && !i_Pop)      count <= count + 1'b1;
      else if (!i_Push && i_Pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Push) mem[wr_ptr] <= i_Push_Entry;
  end

  assign o_Head  = mem[rd_ptr];
  assign o_Full  = (count == CNT_W'(DEPTH));
  assign o_Empty = (count == '0);

endmodule

// File: rtl/bpred_update_queue.sv
// Speculative GHR plus in-order queue of predicted branches that emits
// counter-table update pulses; BPRED_STATS_EN adds saturating event counters.
module bpred_update_queue
  import bpred_pkg::*;
#(
  parameter int unsigned BPRED_WIDTH = BPRED_WIDTH_DEFAULT,
  parameter int unsigned QUEUE_DEPTH = QUEUE_DEPTH_DEFAULT
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset_n,
  input  logic                   i_Fetch_Branch_Valid,
  input  logic [BPRED_WIDTH-1:0] i_Fetch_PC_Bits,
  input  logic                   i_Prediction,
  output logic [BPRED_WIDTH-1:0] o_Index,
  output logic                   o_Full,
  input  logic                   i_ALU_Branch_Valid,
  input  logic                   i_ALU_Branch_Outcome,
  output logic                   o_Update_Valid,
  output logic [BPRED_WIDTH-1:0] o_Update_Index,
  output logic                   o_Update_Outcome,
  output logic                   o_Mispredict,
  output logic [BPRED_WIDTH-1:0] o_GHR
`ifdef BPRED_STATS_EN
  ,
  output logic [31:0]            o_Branch_Count,
  output logic [31:0]            o_Mispredict_Count
`endif
);

  bpred_entry_t           push_entry;
  bpred_entry_t           head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   resolve;
  logic                   mispredict;
  logic                   push;
  logic                   resolved_dir;
  logic [BPRED_WIDTH-1:0] ghr;
  logic [BPRED_WIDTH-1:0] head_index;
  logic [BPRED_WIDTH-1:0] head_snapshot;
  logic [BPRED_WIDTH-1:0] ghr_shifted;
  logic [BPRED_WIDTH-1:0] ghr_restored;

  assign o_Index       = i_Fetch_PC_Bits ^ ghr;
  assign o_GHR         = ghr;
  assign o_Full        = fifo_full;
  assign head_index    = BPRED_WIDTH'(head.index);
  assign head_snapshot = BPRED_WIDTH'(head.ghr_snapshot);

  always_comb begin
    resolved_dir = i_ALU_Branch_Outcome ? OUTCOME_TAKEN : OUTCOME_NOT_TAKEN;
    resolve      = i_ALU_Branch_Valid && !fifo_empty;
    mispredict   = resolve && (head.prediction != resolved_dir);
    // A mispredict flushes the queue, so a same-cycle fetch is wrong-path.
    push         = i_Fetch_Branch_Valid && !fifo_full && !mispredict;
    // Truncating {history, new_bit} drops the oldest bit: a left shift-in.
    ghr_shifted  = BPRED_WIDTH'({ghr, i_Prediction});
    ghr_restored = BPRED_WIDTH'({head_snapshot, resolved_dir});
    push_entry.index        = BPRED_MAX_WIDTH'(o_Index);
    push_entry.prediction   = i_Prediction;
    push_entry.ghr_snapshot = BPRED_MAX_WIDTH'(ghr);
  end

  bpred_entry_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .i_Clk        (i_Clk),
    .i_Reset_n    (i_Reset_n),
    .i_Push       (push),
    .i_Push_Entry (push_entry),
    .i_Pop        (resolve),
    .i_Flush      (mispredict),
    .o_Head       (head),
    .o_Full       (fifo_full),
    .o_Empty      (fifo_empty)
  );

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      ghr              <= '0;
      o_Update_Valid   <= 1'b0;
      o_Update_Index   <= '0;
      o_Update_Outcome <= 1'b0;
      o_Mispredict     <= 1'b0;
    end else begin
      o_Update_Valid <= resolve;
      o_Mispredict   <= mispredict;
      if (resolve) begin
        o_Update_Index   <= head_index;
        o_Update_Outcome <= resolved_dir;
      end
      if (mispredict) ghr <= ghr_restored;
      else if (push)  ghr <= ghr_shifted;
    end
  end

`ifdef BPRED_STATS_EN
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_Branch_Count     <= '0;
      o_Mispredict_Count <= '0;
    end else begin
      if (o_Update_Valid && (o_Branch_Count != '1))
        o_Branch_Count <= o_Branch_Count + 1'b1;
      if (o_Mispredict && (o_Mispredict_Count != '1))
        o_Mispredict_Count <= o_Mispredict_Count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bpred_update_queue.sv
// Self-checking bench for bpred_update_queue: directed scenarios with literal
// expectations plus randomized traffic checked against a queue-based model.
`timescale 1ns/1ps
module tb_bpred_update_queue;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         fv    = 1'b0;
  logic [W-1:0] fpc   = '0;
  logic         pred  = 1'b0;
  logic         av    = 1'b0;
  logic         ao    = 1'b0;

  logic [W-1:0] o_Index;
  logic         o_Full;
  logic         o_Update_Valid;
  logic [W-1:0] o_Update_Index;
  logic         o_Update_Outcome;
  logic         o_Mispredict;
  logic [W-1:0] o_GHR;
`ifdef BPRED_STATS_EN
  logic [31:0]  o_Branch_Count;
  logic [31:0]  o_Mispredict_Count;
`endif

  bpred_update_queue #(
    .BPRED_WIDTH (W),
    .QUEUE_DEPTH (D)
  ) dut (
    .i_Clk                (clk),
    .i_Reset_n            (rst_n),
    .i_Fetch_Branch_Valid (fv),
    .i_Fetch_PC_Bits      (fpc),
    .i_Prediction         (pred),
    .o_Index              (o_Index),
    .o_Full               (o_Full),
    .i_ALU_Branch_Valid   (av),
    .i_ALU_Branch_Outcome (ao),
    .o_Update_Valid       (o_Update_Valid),
    .o_Update_Index       (o_Update_Index),
    .o_Update_Outcome     (o_Update_Outcome),
    .o_Mispredict         (o_Mispredict),
    .o_GHR                (o_GHR)
`ifdef BPRED_STATS_EN
    ,
    .o_Branch_Count       (o_Branch_Count),
    .o_Mispredict_Count   (o_Mispredict_Count)
`endif
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an in-order list of outstanding branches and a history value.
  typedef struct {
    logic [W-1:0] idx;
    logic         pred;
    logic [W-1:0] snap;
  } ent_t;

  ent_t         mq[$];
  ent_t         mh;
  logic [W-1:0] m_ghr = '0;
  logic [W-1:0] m_ui  = '0;
  logic         m_uv  = 1'b0;
  logic         m_uo  = 1'b0;
  logic         m_mp  = 1'b0;
  logic [W-1:0] g0;
  bit           was_full;
`ifdef BPRED_STATS_EN
  logic [31:0]  m_bc = '0;
  logic [31:0]  m_mc = '0;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ghr = '0; m_ui = '0; m_uv = 1'b0; m_uo = 1'b0; m_mp = 1'b0;
`ifdef BPRED_STATS_EN
      m_bc = '0; m_mc = '0;
`endif
    end else begin
`ifdef BPRED_STATS_EN
      if (m_uv && m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
      if (m_mp && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
`endif
      g0       = m_ghr;
      was_full = (mq.size() == D);
      m_uv = 1'b0;
      m_mp = 1'b0;
      if (av && mq.size() != 0) begin
        mh   = mq.pop_front();
        m_uv = 1'b1;
        m_ui = mh.idx;
        m_uo = ao;
        m_mp = (mh.pred != ao);
        if (m_mp) begin
          m_ghr = (mh.snap * 2 + ao) % (1 << W);
          mq.delete();
        end
      end
      if (fv && !was_full && !m_mp) begin
        mq.push_back('{idx: fpc ^ g0, pred: pred, snap: g0});
        m_ghr = (g0 * 2 + pred) % (1 << W);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("index", o_Index, fpc ^ m_ghr);
      chk("full", o_Full, (mq.size() == D));
      chk("ghr", o_GHR, m_ghr);
      chk("upd_valid", o_Update_Valid, m_uv);
      chk("mispredict", o_Mispredict, m_mp);
      if (m_uv) begin
        chk("upd_index", o_Update_Index, m_ui);
        chk("upd_outcome", o_Update_Outcome, m_uo);
      end
`ifdef BPRED_STATS_EN
      chk("branch_cnt", o_Branch_Count, m_bc);
      chk("mispred_cnt", o_Mispredict_Count, m_mc);
`endif
    end
  end

  task automatic drive(input logic f, input logic [W-1:0] pc, input logic p,
                       input logic a, input logic o);
    @(posedge clk);
    #1;
    fv = f; fpc = pc; pred = p; av = a; ao = o;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  bit prev_av;

  initial begin
    // Power-on reset, outputs checked while held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ghr", o_GHR, 0);
    chk("rst_full", o_Full, 0);
    chk("rst_uv", o_Update_Valid, 0);
    chk("rst_mp", o_Mispredict, 0);
    chk("rst_ui", o_Update_Index, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // First fetch: index is PC ^ 0, history shifts in the prediction.
    drive(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    @(negedge clk); chk("lit_index_5a", o_Index, 8'h5A);
    idle();
    @(negedge clk); chk("lit_ghr_01", o_GHR, 8'h01);

    // Fill to capacity, then a rejected fifth fetch.
    drive(1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h30, 1'b1, 1'b0, 1'b0);
    idle();
    @(negedge clk); chk("lit_full", o_Full, 1); chk("lit_ghr_0d", o_GHR, 8'h0D);
    drive(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    idle();
    @(negedge clk); chk("lit_full_hold", o_Full, 1); chk("lit_ghr_hold", o_GHR, 8'h0D);

    // Correct resolve of the 0x5A entry.
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    idle();
    @(negedge clk);
    chk("lit_uv", o_Update_Valid, 1); chk("lit_ui_5a", o_Update_Index, 8'h5A);
    chk("lit_uo", o_Update_Outcome, 1); chk("lit_mp0", o_Mispredict, 0);
    idle();
    @(negedge clk); chk("lit_uv_drop", o_Update_Valid, 0); chk("lit_not_full", o_Full, 0);

    // Mispredict of an entry with snapshot 0x03, with a wrong-path fetch alongside.
    do_reset();
    drive(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
    idle();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    idle();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    idle();
    drive(1'b1, 8'h40, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h42, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'h44, 1'b1, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    chk("lit_mp_uv", o_Update_Valid, 1); chk("lit_mp", o_Mispredict, 1);
    chk("lit_mp_ui", o_Update_Index, 8'h43); chk("lit_mp_ghr", o_GHR, 8'h06);
    chk("lit_mp_full", o_Full, 0);

    // Resolve on the now-empty queue produces nothing.
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    idle();
    @(negedge clk); chk("lit_empty_uv", o_Update_Valid, 0); chk("lit_empty_ghr", o_GHR, 8'h06);

    // Flush left occupancy at zero: three fetches do not fill, a fourth does.
    drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk); chk("lit_occ3", o_Full, 0);
    drive(1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk); chk("lit_occ4", o_Full, 1);

    // Asynchronous reset with two entries in flight.
    do_reset();
    drive(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    idle();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_ghr", o_GHR, 0); chk("arst_index", o_Index, 0);
    chk("arst_full", o_Full, 0); chk("arst_uv", o_Update_Valid, 0);
    chk("arst_mp", o_Mispredict, 0); chk("arst_ui", o_Update_Index, 0);
    chk("arst_uo", o_Update_Outcome, 0);
    #3 rst_n = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    idle();
    @(negedge clk); chk("arst_no_pulse", o_Update_Valid, 0);

    // Randomized traffic; resolves never on consecutive cycles, outcomes biased correct.
    do_reset();
    prev_av = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      logic a, o, f;
      f = ($urandom_range(0, 9) < 6);
      a = !prev_av && ($urandom_range(0, 9) < 4);
      if (mq.size() != 0 && $urandom_range(0, 3) != 0) o = mq[0].pred;
      else o = $urandom_range(0, 1);
      drive(f, W'($urandom), 1'($urandom), a, o);
      prev_av = a;
    end
    repeat (4) idle();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
